// File: rtl/m_seq_checker.sv
// m_seq_checker: serial checker for the x^10 + x^3 + 1 maximal-length sequence.
// Seeds a local generator from the first 10 received bits, then compares each
// further bit against the local prediction and counts errors, compared bits
// and 1023-bit periods.
// Optional feature (macro M_SEQ_CHK_RESYNC_EN): LOSS_THRESH errors inside one
// WIN-bit window drop lock and restart acquisition. Without the macro the
// block stays in TRACK after its first lock and only counts errors.
module m_seq_checker #(
    parameter int ERR_W       = 16,
    parameter int BIT_W       = 24,
    parameter int WIN         = 32,
    parameter int LOSS_THRESH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             din_valid,
    input  logic             din,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             period_pulse
);

    typedef enum logic [0:0] {
        ST_ACQ   = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Last value of the mod-1023 period count before it wraps.
    localparam logic [9:0] PER_LAST = 10'd1022;

    // Reject parameter sets the window logic cannot represent.
    if ((WIN < 8) || (WIN > 256) || ((WIN & (WIN - 1)) != 0) ||
        (LOSS_THRESH < 1) || (LOSS_THRESH > WIN)) begin : g_bad_param
        $error("m_seq_checker: WIN must be a power of two in 8..256 and LOSS_THRESH in 1..WIN");
    end

    state_t           r_state;
    logic [9:0]       r_h;            // r_h[0] is the newest bit
    logic [3:0]       r_fill;
    logic [9:0]       r_per;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_period_pulse;
    logic [ERR_W-1:0] r_err_cnt;
    logic [BIT_W-1:0] r_bit_cnt;

    logic             w_pred;
    logic             w_mism;
    logic             w_per_wrap;
    logic             w_loss;
    logic [9:0]       w_h_acq;

`ifdef M_SEQ_CHK_RESYNC_EN
    localparam int WIN_AW = $clog2(WIN);
    localparam int WE_W   = $clog2(LOSS_THRESH + 1);

    logic [WIN_AW-1:0] r_win;
    logic [WE_W-1:0]   r_win_err;
    logic              w_win_wrap;
    logic [WE_W-1:0]   w_win_err_inc;
`endif

    // Prediction a[n] = a[n-7] ^ a[n-10], mismatch, wrap and lock-loss decode.
    always_comb begin
        w_pred     = r_h[9] ^ r_h[6];
        w_mism     = din ^ w_pred;
        w_h_acq    = {r_h[8:0], din};
        w_per_wrap = (r_per == PER_LAST);
`ifdef M_SEQ_CHK_RESYNC_EN
        w_win_wrap    = (r_win == WIN_AW'(WIN - 1));
        w_win_err_inc = r_win_err + WE_W'(w_mism);
        w_loss        = w_mism && (w_win_err_inc == WE_W'(LOSS_THRESH));
`else
        w_loss        = 1'b0;
`endif
    end

    // Acquisition/tracking state machine with registered outputs and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_ACQ;
            r_h            <= 10'd0;
            r_fill         <= 4'd0;
            r_per          <= 10'd0;
            r_locked       <= 1'b0;
            r_err_pulse    <= 1'b0;
            r_period_pulse <= 1'b0;
            r_err_cnt      <= {ERR_W{1'b0}};
            r_bit_cnt      <= {BIT_W{1'b0}};
`ifdef M_SEQ_CHK_RESYNC_EN
            r_win          <= {WIN_AW{1'b0}};
            r_win_err      <= {WE_W{1'b0}};
`endif
        end else if (clr) begin
            // clr wins over din_valid; the sample of this cycle is dropped.
            r_state        <= ST_ACQ;
            r_h            <= 10'd0;
            r_fill         <= 4'd0;
            r_per          <= 10'd0;
            r_locked       <= 1'b0;
            r_err_pulse    <= 1'b0;
            r_period_pulse <= 1'b0;
            r_err_cnt      <= {ERR_W{1'b0}};
            r_bit_cnt      <= {BIT_W{1'b0}};
`ifdef M_SEQ_CHK_RESYNC_EN
            r_win          <= {WIN_AW{1'b0}};
            r_win_err      <= {WE_W{1'b0}};
`endif
        end else begin
            r_err_pulse    <= 1'b0;
            r_period_pulse <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    ST_ACQ: begin
                        r_h <= w_h_acq;
                        if (r_fill == 4'd9) begin
                            r_fill <= 4'd0;
                            // An all-zero seed would predict zeros forever.
                            if (w_h_acq != 10'd0) begin
                                r_state  <= ST_TRACK;
                                r_locked <= 1'b1;
                            end else begin
                                r_state  <= ST_ACQ;
                                r_locked <= 1'b0;
                            end
                        end else begin
                            r_fill <= r_fill + 4'd1;
                        end
                    end
                    ST_TRACK: begin
                        // Free-running local generator: a flipped input bit
                        // never corrupts later predictions.
                        r_h            <= {r_h[8:0], w_pred};
                        r_per          <= w_per_wrap ? 10'd0 : (r_per + 10'd1);
                        r_period_pulse <= w_per_wrap;
                        if (r_bit_cnt != {BIT_W{1'b1}}) begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                        if (w_mism) begin
                            r_err_pulse <= 1'b1;
                            if (r_err_cnt != {ERR_W{1'b1}}) begin
                                r_err_cnt <= r_err_cnt + ERR_W'(1);
                            end
                        end
`ifdef M_SEQ_CHK_RESYNC_EN
                        if (w_loss) begin
                            r_state   <= ST_ACQ;
                            r_locked  <= 1'b0;
                            r_fill    <= 4'd0;
                            r_per     <= 10'd0;
                            r_win     <= {WIN_AW{1'b0}};
                            r_win_err <= {WE_W{1'b0}};
                        end else begin
                            r_win     <= r_win + WIN_AW'(1);
                            r_win_err <= w_win_wrap ? {WE_W{1'b0}} : w_win_err_inc;
                        end
`endif
                    end
                    default: begin
                        r_state  <= ST_ACQ;
                        r_locked <= 1'b0;
                        r_fill   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign locked       = r_locked;
    assign err_pulse    = r_err_pulse;
    assign err_cnt      = r_err_cnt;
    assign bit_cnt      = r_bit_cnt;
    assign period_pulse = r_period_pulse;

endmodule
